ad7686_rx: RTL and testbench



---
 rtl/ad7686_rx.sv | 151 +++++++++++++++
 tb/tb_ad7686_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad7686_rx.sv
// SPI capture front end for a 16-bit SAR ADC (AD7686 family).
// Periodic convst, then a cs_n/sclk read whose sample is put on an AXI-stream master.
module ad7686_rx #(
    parameter int DW            = 16,
    parameter int IFREQ         = 96,
    parameter int CONV_CYC      = 4,
    parameter int SCLK_HALF     = 2,
    parameter int SAMPLE_PERIOD = 100
) (
    input  logic          m_axis_aclk,
    input  logic          m_axis_areset,
    input  logic          en,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          convst,
    output logic          cs_n,
    output logic          sclk,
    input  logic          sdo,
    output logic          overrun,
    output logic          missed
);

    localparam int CMAX = (CONV_CYC > SCLK_HALF) ? CONV_CYC : SCLK_HALF;
    localparam int PW   = $clog2(SAMPLE_PERIOD + 1);
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(DW + 1);

    localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CONV_CYC - 1);
    localparam logic [CW-1:0] H_LAST = CW'(SCLK_HALF - 1);
    localparam logic [BW-1:0] B_ALL  = BW'(DW);

    if (SCLK_HALF < 1 || CONV_CYC < 1 || DW < 2 || IFREQ < 1) begin : g_bad_param
        $error("ad7686_rx: bad parameters");
    end

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pcnt;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [DW-1:0] sr, sr_n;
    logic          convst_n, cs_n_n, sclk_n;
    logic          trigger, load;

    assign trigger = en && (pcnt == '0);
    assign load    = (state == DONE) && (!m_axis_tvalid || m_axis_tready);

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset)      pcnt <= '0;
        else if (!en)           pcnt <= '0;
        else if (pcnt == P_LAST) pcnt <= '0;
        else                    pcnt <= pcnt + 1'b1;
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bcnt_n   = bcnt;
        sr_n     = sr;
        convst_n = convst;
        cs_n_n   = cs_n;
        sclk_n   = sclk;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_n  = CONV;
                    convst_n = 1'b1;
                    cnt_n    = '0;
                end
            end
            CONV: begin
                if (cnt == C_LAST) begin
                    state_n  = SHIFT;
                    convst_n = 1'b0;
                    cs_n_n   = 1'b0;
                    sclk_n   = 1'b0;
                    cnt_n    = '0;
                    bcnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == H_LAST) begin
                    cnt_n  = '0;
                    sclk_n = !sclk;
                    // capture on the edge that raises sclk; sdo is stable since the last fall
                    if (!sclk) begin
                        sr_n   = {sr[DW-2:0], sdo};
                        bcnt_n = bcnt + 1'b1;
                    end else if (bcnt == B_ALL) begin
                        state_n = DONE;
                        sclk_n  = 1'b0;
                        cs_n_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            state  <= IDLE;
            cnt    <= '0;
            bcnt   <= '0;
            sr     <= '0;
            convst <= 1'b0;
            cs_n   <= 1'b1;
            sclk   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bcnt   <= bcnt_n;
            sr     <= sr_n;
            convst <= convst_n;
            cs_n   <= cs_n_n;
            sclk   <= sclk_n;
        end
    end

    // a pending beat is never overwritten; a sample that finds it stuck is dropped
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            overrun       <= 1'b0;
            missed        <= 1'b0;
        end else begin
            overrun <= (state == DONE) && !load;
            missed  <= trigger && (state != IDLE);
            if (load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= sr;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ad7686_rx.sv
// Directed bench for ad7686_rx: default instance plus a SAMPLE_PERIOD=50 instance.
// Each DUT reads from a small ADC model that shifts words out on sclk falls.
module tb_ad7686_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, tready;
    logic        tvalid, convst, cs_n, sclk, sdo, overrun, missed;
    logic [15:0] tdata;

    logic        en50, tready50;
    logic        tvalid50, convst50, cs_n50, sclk50, sdo50, overrun50, missed50;
    logic [15:0] tdata50;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ad7686_rx dut (
        .m_axis_aclk   (clk),
        .m_axis_areset (rst),
        .en            (en),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .convst        (convst),
        .cs_n          (cs_n),
        .sclk          (sclk),
        .sdo           (sdo),
        .overrun       (overrun),
        .missed        (missed)
    );

    ad7686_rx #(.SAMPLE_PERIOD(50)) dut50 (
        .m_axis_aclk   (clk),
        .m_axis_areset (rst),
        .en            (en50),
        .m_axis_tvalid (tvalid50),
        .m_axis_tready (tready50),
        .m_axis_tdata  (tdata50),
        .convst        (convst50),
        .cs_n          (cs_n50),
        .sclk          (sclk50),
        .sdo           (sdo50),
        .overrun       (overrun50),
        .missed        (missed50)
    );

    logic [15:0] words [9];
    logic [15:0] cur_word = '0;
    int          widx = 0;
    int          bidx = 0;

    initial begin
        words[0] = 16'hA5C3; words[1] = 16'h0001; words[2] = 16'hFFFF;
        words[3] = 16'h1234; words[4] = 16'h5678; words[5] = 16'h9ABC;
        words[6] = 16'h0F0F; words[7] = 16'hC0DE; words[8] = 16'hBEEF;
    end

    initial sdo = 1'b0;
    always @(negedge cs_n) begin
        cur_word = words[widx];
        widx++;
        bidx = 15;
        sdo = cur_word[bidx];
    end
    always @(negedge sclk) begin
        if (bidx > 0) begin
            bidx--;
            sdo = cur_word[bidx];
        end
    end

    logic [15:0] word50 = 16'h3C3C;
    int          bidx50 = 0;
    initial sdo50 = 1'b0;
    always @(negedge cs_n50) begin
        bidx50 = 15;
        sdo50 = word50[bidx50];
    end
    always @(negedge sclk50) begin
        if (bidx50 > 0) begin
            bidx50--;
            sdo50 = word50[bidx50];
        end
    end

    int   rises = 0, lowcnt = 0, conv_rises = 0;
    int   ovr_cnt = 0, mis_cnt = 0, mis50_cnt = 0;
    int   beats = 0, beats_1234 = 0;
    logic prev_sclk = 1'b0, prev_convst = 1'b0;

    always @(negedge clk) begin
        if (sclk && !prev_sclk) rises++;
        if (convst && !prev_convst) conv_rises++;
        if (!cs_n) lowcnt++;
        if (overrun) ovr_cnt++;
        if (missed) mis_cnt++;
        if (missed50) mis50_cnt++;
        prev_sclk   = sclk;
        prev_convst = convst;
    end

    always @(posedge clk) begin
        if (tvalid && tready) begin
            beats++;
            if (tdata == 16'h1234) beats_1234++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic at(input int k);
        do @(negedge clk); while (cyc < t0 + k);
    endtask

    int snap;

    initial begin
        rst = 1'b1; en = 1'b0; tready = 1'b1;
        en50 = 1'b0; tready50 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tdata", 32'(tdata), 32'h0);
        check("rst_convst", 32'(convst), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_flags", {30'd0, overrun, missed}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // first sample, both instances triggered together
        en = 1'b1; en50 = 1'b1; t0 = cyc;
        check("t0_convst", 32'(convst), 32'd0);
        at(1);   check("t1_convst", 32'(convst), 32'd1);
        at(4);   check("t4_convst", 32'(convst), 32'd1);
                 check("t4_cs_n", 32'(cs_n), 32'd1);
        at(5);   check("t5_convst", 32'(convst), 32'd0);
                 check("t5_cs_n", 32'(cs_n), 32'd0);
        at(6);   check("t6_sclk", 32'(sclk), 32'd0);
        at(7);   check("t7_sclk", 32'(sclk), 32'd1);
        at(51);  check("p50_missed1", 32'(missed50), 32'd1);
        at(68);  check("t68_cs_n", 32'(cs_n), 32'd0);
        at(69);  check("t69_cs_n", 32'(cs_n), 32'd1);
                 check("t69_tvalid", 32'(tvalid), 32'd0);
        at(70);  check("t70_tvalid", 32'(tvalid), 32'd1);
                 check("t70_tdata", 32'(tdata), 32'hA5C3);
                 check("p50_tvalid70", 32'(tvalid50), 32'd1);
                 check("p50_tdata70", 32'(tdata50), 32'h3C3C);
        at(71);  check("t71_tvalid", 32'(tvalid), 32'd0);
        at(72);  check("sclk_rises", 32'(rises), 32'd16);
                 check("cs_low_clocks", 32'(lowcnt), 32'd64);

        // back-to-back beats
        at(151); check("p50_missed2", 32'(missed50), 32'd1);
        at(170); check("b2b_tvalid1", 32'(tvalid), 32'd1);
                 check("b2b_tdata1", 32'(tdata), 32'h0001);
                 check("p50_tvalid170", 32'(tvalid50), 32'd1);
        at(171); check("b2b_tvalid1_off", 32'(tvalid), 32'd0);
        at(270); check("b2b_tvalid2", 32'(tvalid), 32'd1);
                 check("b2b_tdata2", 32'(tdata), 32'hFFFF);
                 check("p50_tvalid270", 32'(tvalid50), 32'd1);
        at(272); check("b2b_overrun", 32'(ovr_cnt), 32'd0);
                 check("b2b_missed", 32'(mis_cnt), 32'd0);
                 check("p50_missed_cnt", 32'(mis50_cnt), 32'd3);
        at(280); en50 = 1'b0;

        // backpressure: pending beat held, later samples dropped
        at(325); tready = 1'b0;
        at(370); check("bp_tvalid", 32'(tvalid), 32'd1);
                 check("bp_tdata", 32'(tdata), 32'h1234);
        at(470); check("bp_overrun1", 32'(overrun), 32'd1);
                 check("bp_hold1", 32'(tdata), 32'h1234);
        at(570); check("bp_overrun2", 32'(overrun), 32'd1);
                 check("bp_hold2", 32'({tvalid, tdata}), 32'h11234);
        at(575); tready = 1'b1;
        at(576); check("bp_tvalid_off", 32'(tvalid), 32'd0);
                 check("bp_beats_1234", 32'(beats_1234), 32'd1);
        at(580); check("bp_overrun_cnt", 32'(ovr_cnt), 32'd2);

        // en dropped mid-transaction
        at(610); en = 1'b0;
        snap = conv_rises;
        at(670); check("en_tvalid", 32'(tvalid), 32'd1);
                 check("en_tdata", 32'(tdata), 32'h0F0F);
        at(800); check("en_no_convst", 32'(conv_rises), 32'(snap));
                 check("en_missed", 32'(mis_cnt), 32'd0);

        // reset while shifting
        en = 1'b1; t0 = cyc;
        at(31);  check("rs_cs_n_pre", 32'(cs_n), 32'd0);
                 check("rs_sclk_pre", 32'(sclk), 32'd1);
        rst = 1'b1;
        #1;
        check("rs_cs_n", 32'(cs_n), 32'd1);
        check("rs_sclk", 32'(sclk), 32'd0);
        check("rs_tvalid", 32'(tvalid), 32'd0);
        snap = beats;
        at(34);
        rst = 1'b0; t0 = cyc;
        at(5);   check("rs_cs_n_low", 32'(cs_n), 32'd0);
        at(69);  check("rs_no_beat", 32'(beats), 32'(snap));
                 check("rs_tvalid69", 32'(tvalid), 32'd0);
        at(70);  check("rs_tvalid70", 32'(tvalid), 32'd1);
                 check("rs_tdata70", 32'(tdata), 32'hBEEF);
        at(72);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
